// File: rtl/pong_video_pkg.sv
// Shared video-path definitions for the pong game pipeline.
// Holds the default frame geometry and the state encoding of the
// hand centroid tracker. No ports; imported by the tracker files.
package pong_video_pkg;

   localparam int VID_Y_WIDTH  = 10;
   localparam int VID_Y_MAX    = 479;
   localparam int VID_CENTER_Y = 240;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DIVIDE = 2'd1,
      DONE   = 2'd2
   } track_state_t;

endpackage

// File: rtl/hand_centroid_tracker_if.sv
// Pixel-stream and position-update bundle of the hand centroid tracker.
// Pixel side : iValid, iHit, iY, iEOF (driven by the colour-detection stage)
// Result side: oPaddleY, oMinY, oMaxY, oFound, oValid, oOverrun
// master = stream source / result consumer, slave = tracker.
interface hand_centroid_tracker_if
   import pong_video_pkg::*;
#(
   parameter int Y_WIDTH = VID_Y_WIDTH
);
   logic               iValid;
   logic               iHit;
   logic [Y_WIDTH-1:0] iY;
   logic               iEOF;
   logic [Y_WIDTH-1:0] oPaddleY;
   logic [Y_WIDTH-1:0] oMinY;
   logic [Y_WIDTH-1:0] oMaxY;
   logic               oFound;
   logic               oValid;
   logic               oOverrun;

   modport master (
      output iValid, iHit, iY, iEOF,
      input  oPaddleY, oMinY, oMaxY, oFound, oValid, oOverrun
   );

   modport slave (
      input  iValid, iHit, iY, iEOF,
      output oPaddleY, oMinY, oMaxY, oFound, oValid, oOverrun
   );
endinterface

// File: rtl/seq_udivider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   start     load dividend/divisor and begin (ignored handling while busy
//             is the caller's responsibility)
//   dividend  SUM_WIDTH-bit numerator
//   divisor   CNT_WIDTH-bit denominator, must be non-zero
//   busy      iterations outstanding
//   done      high during the cycle whose closing edge completes the last
//             iteration
//   quotient  quotient as it will stand after the current iteration; equals
//             the final result while done is high
module seq_udivider #(
   parameter int SUM_WIDTH = 28,
   parameter int CNT_WIDTH = 19
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [SUM_WIDTH-1:0] dividend,
   input  logic [CNT_WIDTH-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [SUM_WIDTH-1:0] quotient
);

   localparam int ITER_W = $clog2(SUM_WIDTH + 1);

   logic [ITER_W-1:0]    iter_q;
   logic [SUM_WIDTH-1:0] quo_q;
   logic [CNT_WIDTH-1:0] dsr_q;
   logic [CNT_WIDTH-1:0] rem_q;
   logic [CNT_WIDTH:0]   rem_shift;
   logic [CNT_WIDTH:0]   rem_diff;
   logic                 take;
   logic [CNT_WIDTH-1:0] rem_next;
   logic [SUM_WIDTH-1:0] quo_next;

   // quo_q starts as the dividend; its MSB feeds the remainder each step and
   // the freed LSB receives the new quotient bit.
   always_comb begin
      rem_shift = {rem_q, quo_q[SUM_WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, dsr_q};
      take      = (rem_shift >= {1'b0, dsr_q});
      // Remainder stays below the divisor, so CNT_WIDTH bits always suffice.
      rem_next  = take ? rem_diff[CNT_WIDTH-1:0] : rem_shift[CNT_WIDTH-1:0];
      quo_next  = {quo_q[SUM_WIDTH-2:0], take};
   end

   assign busy     = (iter_q != '0);
   assign done     = (iter_q == ITER_W'(1));
   assign quotient = quo_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_q <= '0;
      end else if (start) begin
         iter_q <= ITER_W'(SUM_WIDTH);
      end else if (busy) begin
         iter_q <= iter_q - ITER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         quo_q <= dividend;
         dsr_q <= divisor;
         rem_q <= '0;
      end else if (busy) begin
         quo_q <= quo_next;
         rem_q <= rem_next;
      end
   end

endmodule

// File: rtl/hand_centroid_tracker.sv
// Per-frame hand position tracker. Accumulates hit count, Y-sum and the
// hit row extent over a frame, divides sum by count after end of frame and
// publishes one registered paddle position update per frame.
// Ports:
//   iCLK  pixel clock
//   iRST  asynchronous active-high reset
//   trk   slave side of hand_centroid_tracker_if (pixel stream in,
//         oPaddleY/oMinY/oMaxY/oFound/oValid/oOverrun out)
module hand_centroid_tracker
   import pong_video_pkg::*;
#(
   parameter int Y_WIDTH    = VID_Y_WIDTH,
   parameter int CNT_WIDTH  = 19,
   parameter int SUM_WIDTH  = 28,
   parameter int MIN_PIXELS = 64,
   parameter int Y_MAX      = VID_Y_MAX,
   parameter int CENTER_Y   = VID_CENTER_Y
) (
   input logic                     iCLK,
   input logic                     iRST,
   hand_centroid_tracker_if.slave  trk
);

   localparam logic [Y_WIDTH-1:0]   Y_LIM   = Y_WIDTH'(Y_MAX);
   localparam logic [Y_WIDTH-1:0]   Y_CTR   = Y_WIDTH'(CENTER_Y);
   localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_PIXELS);

   function automatic logic [Y_WIDTH-1:0] sat_row(input logic [SUM_WIDTH-1:0] q);
      if (q > SUM_WIDTH'(Y_MAX)) sat_row = Y_LIM;
      else                       sat_row = q[Y_WIDTH-1:0];
   endfunction

   track_state_t state, state_next;

   logic [CNT_WIDTH-1:0] cnt_acc, cnt_upd;
   logic [SUM_WIDTH-1:0] sum_acc, sum_upd;
   logic [SUM_WIDTH:0]   sum_wide;
   logic [Y_WIDTH-1:0]   miny_acc, miny_upd, maxy_acc, maxy_upd;
   logic [Y_WIDTH-1:0]   hold_min, hold_max;
   logic                 qual;

   logic                 snap, start_div, publish, publish_found, overrun;
   logic                 div_busy, div_done;
   logic [SUM_WIDTH-1:0] div_quot;

   logic [Y_WIDTH-1:0]   paddle_r, miny_r, maxy_r;
   logic                 found_r, valid_r, overrun_r;

   // Accumulator update including this cycle's pixel, so a hit that arrives
   // with iEOF is part of the snapshot of the ending frame.
   always_comb begin
      qual     = trk.iValid & trk.iHit & (trk.iY <= Y_LIM);
      cnt_upd  = cnt_acc;
      sum_upd  = sum_acc;
      miny_upd = miny_acc;
      maxy_upd = maxy_acc;
      sum_wide = {1'b0, sum_acc} + (SUM_WIDTH + 1)'(trk.iY);
      if (qual) begin
         cnt_upd = (&cnt_acc) ? cnt_acc : cnt_acc + CNT_WIDTH'(1);
         sum_upd = sum_wide[SUM_WIDTH] ? '1 : sum_wide[SUM_WIDTH-1:0];
         if (trk.iY < miny_acc) miny_upd = trk.iY;
         if (trk.iY > maxy_acc) maxy_upd = trk.iY;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         cnt_acc  <= '0;
         sum_acc  <= '0;
         miny_acc <= '1;
         maxy_acc <= '0;
      end else if (trk.iEOF) begin
         // Every end of frame restarts accumulation, dropped frames included.
         cnt_acc  <= '0;
         sum_acc  <= '0;
         miny_acc <= '1;
         maxy_acc <= '0;
      end else begin
         cnt_acc  <= cnt_upd;
         sum_acc  <= sum_upd;
         miny_acc <= miny_upd;
         maxy_acc <= maxy_upd;
      end
   end

   always_ff @(posedge iCLK) begin
      if (snap) begin
         hold_min <= miny_upd;
         hold_max <= maxy_upd;
      end
   end

   seq_udivider #(
      .SUM_WIDTH (SUM_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_div (
      .clk      (iCLK),
      .rst      (iRST),
      .start    (start_div),
      .dividend (sum_upd),
      .divisor  (cnt_upd),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quot)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= ACCUM;
      else      state <= state_next;
   end

   always_comb begin
      state_next    = state;
      snap          = 1'b0;
      start_div     = 1'b0;
      publish       = 1'b0;
      publish_found = 1'b0;
      overrun       = 1'b0;
      case (state)
         ACCUM: begin
            if (trk.iEOF) begin
               snap = 1'b1;
               if (cnt_upd >= MIN_CNT) begin
                  start_div  = 1'b1;
                  state_next = DIVIDE;
               end else begin
                  publish    = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DIVIDE: begin
            overrun = trk.iEOF;
            if (div_done) begin
               publish       = 1'b1;
               publish_found = 1'b1;
               state_next    = DONE;
            end else if (!div_busy) begin
               // Divider idle while we wait on it: recover instead of hanging.
               state_next = ACCUM;
            end
         end
         DONE: begin
            overrun    = trk.iEOF;
            state_next = ACCUM;
         end
         default: state_next = ACCUM;
      endcase
   end

   // Output registers load on the edge that enters DONE, so they change
   // exactly when oValid rises.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         paddle_r  <= Y_CTR;
         miny_r    <= '1;
         maxy_r    <= '0;
         found_r   <= 1'b0;
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         valid_r   <= publish;
         overrun_r <= overrun;
         if (publish_found) begin
            paddle_r <= sat_row(div_quot);
            miny_r   <= hold_min;
            maxy_r   <= hold_max;
            found_r  <= 1'b1;
         end else if (publish) begin
            found_r  <= 1'b0;
         end
      end
   end

   assign trk.oPaddleY = paddle_r;
   assign trk.oMinY    = miny_r;
   assign trk.oMaxY    = maxy_r;
   assign trk.oFound   = found_r;
   assign trk.oValid   = valid_r;
   assign trk.oOverrun = overrun_r;

endmodule

// File: tb/tb_hand_centroid_tracker.sv
// Scoreboard bench for hand_centroid_tracker: stimulus pushes the expected
// update (with its arrival cycle) and expected overrun pulses into queues;
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_hand_centroid_tracker;

   typedef struct {
      int cyc;
      int py;
      int mn;
      int mx;
      int found;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   passed;

   exp_t exp_q[$];
   int   ov_q[$];
   exp_t mon_e;
   int   mon_c;

   hand_centroid_tracker_if #(.Y_WIDTH(10)) bus ();

   hand_centroid_tracker dut (
      .iCLK (clk),
      .iRST (rst),
      .trk  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual == expected) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // Monitor: compare on every output pulse.
   always @(negedge clk) begin
      if (bus.oValid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_oValid", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("valid_cycle", cyc, mon_e.cyc);
            check("oPaddleY", int'(bus.oPaddleY), mon_e.py);
            check("oMinY", int'(bus.oMinY), mon_e.mn);
            check("oMaxY", int'(bus.oMaxY), mon_e.mx);
            check("oFound", int'(bus.oFound), mon_e.found);
         end
      end
      if (bus.oOverrun) begin
         if (ov_q.size() == 0) begin
            check("unexpected_oOverrun", 1, 0);
         end else begin
            mon_c = ov_q.pop_front();
            check("overrun_cycle", cyc, mon_c);
         end
      end
   end

   task automatic pix(input int row, input int n, input bit v, input bit h);
      for (int i = 0; i < n; i++) begin
         bus.iValid = v;
         bus.iHit   = h;
         bus.iY     = 10'(row);
         @(posedge clk);
         #1;
      end
      bus.iValid = 1'b0;
      bus.iHit   = 1'b0;
   endtask

   // End of frame. found selects the expected latency (28 extra edges for
   // the divider); e returns the count of the edge that samples iEOF.
   task automatic frame_end(input bit with_hit, input int row, input bit push,
                            input bit found, input int py, input int mn,
                            input int mx, output int e);
      exp_t x;
      bus.iEOF = 1'b1;
      if (with_hit) begin
         bus.iValid = 1'b1;
         bus.iHit   = 1'b1;
         bus.iY     = 10'(row);
      end
      e = cyc + 1;
      if (push) begin
         x.cyc   = e + (found ? 28 : 0);
         x.py    = py;
         x.mn    = mn;
         x.mx    = mx;
         x.found = found ? 1 : 0;
         exp_q.push_back(x);
      end
      @(posedge clk);
      #1;
      bus.iEOF   = 1'b0;
      bus.iValid = 1'b0;
      bus.iHit   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_oPaddleY"}, int'(bus.oPaddleY), 240);
      check({tag, "_oMinY"}, int'(bus.oMinY), 1023);
      check({tag, "_oMaxY"}, int'(bus.oMaxY), 0);
      check({tag, "_oFound"}, int'(bus.oFound), 0);
      check({tag, "_oValid"}, int'(bus.oValid), 0);
      check({tag, "_oOverrun"}, int'(bus.oOverrun), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int e1;
      int wait_cnt;
      total      = 0;
      passed     = 0;
      rst        = 1'b1;
      bus.iValid = 1'b0;
      bus.iHit   = 1'b0;
      bus.iY     = '0;
      bus.iEOF   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Too few hits: not found, previous (reset) values held, valid at T+1.
      pix(300, 63, 1, 1);
      frame_end(0, 0, 1, 0, 240, 1023, 0, e);

      // Rows 100..119, 20 hits each: 43800 / 400 = 109.
      for (int r = 100; r < 120; r++) pix(r, 20, 1, 1);
      frame_end(0, 0, 1, 1, 109, 100, 119, e);

      // Hits with iValid low, valid non-hits and out-of-range rows are ignored.
      pix(3, 5, 0, 1);
      pix(5, 6, 1, 0);
      pix(500, 5, 1, 1);
      pix(10, 64, 1, 1);
      frame_end(0, 0, 1, 1, 10, 10, 10, e);

      // Last hit arrives with iEOF: 32 on row 0 + 32 on row 200 -> 100.
      pix(0, 32, 1, 1);
      pix(200, 31, 1, 1);
      frame_end(1, 200, 1, 1, 100, 0, 200, e);

      // Second iEOF 10 edges into the division: overrun, first result on time.
      pix(50, 64, 1, 1);
      frame_end(0, 0, 1, 1, 50, 50, 50, e1);
      pix(400, 8, 1, 1);
      @(posedge clk);
      #1;
      ov_q.push_back(cyc + 1);
      frame_end(0, 0, 0, 0, 0, 0, 0, e);
      check("second_eof_offset", e - e1, 10);
      // Row-400 hits were discarded; a leftover would raise oMaxY.
      pix(30, 64, 1, 1);
      frame_end(0, 0, 1, 1, 30, 30, 30, e);

      // Reset at T+15 of a division: immediate reset outputs, no oValid.
      pix(70, 64, 1, 1);
      frame_end(0, 0, 0, 0, 0, 0, 0, e);
      while (cyc < e + 15) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      pix(150, 64, 1, 1);
      frame_end(0, 0, 1, 1, 150, 150, 150, e);

      wait_cnt = 0;
      while ((exp_q.size() != 0 || ov_q.size() != 0) && wait_cnt < 100) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      repeat (5) @(posedge clk);
      #1;
      check("pending_updates", exp_q.size(), 0);
      check("pending_overruns", ov_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hand_centroid_tracker.md
# hand_centroid_tracker

Per-frame hand position tracker that consumes the per-pixel hand-match stream produced by the colour-detection stage and converts it into a paddle Y coordinate for the pong game logic. Over each video frame it accumulates the count and Y-sum of matching pixels inside the active area. At end of frame it computes the vertical centroid with a sequential divider. It then presents one registered position update per frame, with a found/not-found flag and bounding rows.

## Interface
- Y_WIDTH, 10: width of pixel Y coordinate.
- CNT_WIDTH, 19: hit-counter width; holds 640×480 = 307200 without overflow.
- SUM_WIDTH, 28: Y-sum accumulator width; also the divider iteration count.
- MIN_PIXELS, 64: minimum hits per frame for a valid detection.
- Y_MAX, 479: last active row; hits with iY > Y_MAX are ignored.
- CENTER_Y, 240: reset and default paddle position.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous, active-high reset.
- iValid  in  1  active-area pixel strobe; iHit and iY are sampled only when high.
- iHit  in  1  pixel matched hand colour (detection output red channel == 8'hFF).
- iY  in  Y_WIDTH  row of current pixel.
- iEOF  in  1  single-cycle end-of-frame pulse.
- oPaddleY  out  Y_WIDTH  centroid row of the last valid frame.
- oMinY  out  Y_WIDTH  topmost hit row of the last valid frame.
- oMaxY  out  Y_WIDTH  bottom hit row of the last valid frame.
- oFound  out  1  last completed frame met MIN_PIXELS.
- oValid  out  1  one-cycle pulse when the outputs have been updated.
- oOverrun  out  1  one-cycle pulse when a frame result was dropped.

## Operation
- Reset values: oPaddleY = CENTER_Y, oMinY = all-ones, oMaxY = 0, oFound = 0, oValid = 0, oOverrun = 0, accumulators cleared, state ACCUM.
- ACCUM: on each cycle with iValid & iHit & (iY ≤ Y_MAX):
  - count += 1, saturating at all-ones.
  - sum += iY, saturating at all-ones.
  - minY = min(minY, iY).
  - maxY = max(maxY, iY).
- A pixel qualifying in the same cycle as iEOF belongs to the ending frame.
- On iEOF in ACCUM:
  - Snapshot count, sum, minY and maxY into the divider/hold registers.
  - Clear the accumulators in the same edge.
  - If the snapshotted count ≥ MIN_PIXELS, go to DIVIDE; otherwise go to DONE with the not-found flag.
- DIVIDE: unsigned restoring division, sum / count, one quotient bit per cycle, exactly SUM_WIDTH cycles, MSB first. Accumulation of the next frame continues in parallel.
- DONE, one cycle:
  - Found: oPaddleY = min(quotient, Y_MAX), oMinY/oMaxY = snapshot, oFound = 1.
  - Not found: oPaddleY, oMinY and oMaxY hold their previous values, oFound = 0.
  - In both cases oValid = 1, then return to ACCUM.
- iEOF while in DIVIDE or DONE:
  - Accumulators clear and restart.
  - The ending frame's data is discarded.
  - oOverrun pulses on the next cycle.
  - The in-flight division completes normally.
- Count is never zero when dividing, because MIN_PIXELS ≥ 1 is required; MIN_PIXELS = 0 is illegal.

## Timing
- iEOF sampled at edge T.
- Found path: DIVIDE covers T+1 … T+SUM_WIDTH, DONE is at T+SUM_WIDTH+1, and oValid is high in that cycle (T+29 at default parameters).
- Not-found path: DONE at T+1, oValid high in cycle T+1.
- All outputs are registered; oPaddleY, oMinY, oMaxY and oFound change only on the edge that raises oValid.
- Asynchronous iRST mid-DIVIDE aborts the division: outputs go to reset values and no oValid is issued.

## Structure
- Shared package `pong_video_pkg`: Y_WIDTH, Y_MAX, CENTER_Y, and the state enum {ACCUM, DIVIDE, DONE}.
- One sub-module: `seq_udivider` (start/busy/done, SUM_WIDTH dividend, CNT_WIDTH divisor, SUM_WIDTH-cycle latency).
- The tracker keeps the accumulators, snapshot registers, FSM and output registers.

## Test plan
- Rows 100–119 each with 20 hits (400 hits), then iEOF → after 29 cycles, oValid with oPaddleY = 109, oMinY = 100, oMaxY = 119, oFound = 1.
- 63 hits on row 300, then iEOF → oValid at T+1 with oFound = 0 and oPaddleY held (240 after reset).
- Hits with iY = 500 plus 64 hits on row 10 → oPaddleY = 10; the out-of-range rows do not affect oMaxY.
- Final hit on row 200 asserted together with iEOF, 64 hits total on rows 0 and 200 (32 each) → included in the ending frame, oPaddleY = 100.
- Second iEOF 10 cycles after the first → oOverrun pulses; the first frame's oValid still arrives on schedule; the next frame starts from cleared accumulators.
- iRST asserted at T+15 of a division → outputs at reset values immediately, no oValid; the following frame processes normally.
